// File: rtl/leaf_quad_arb_if.sv
// Leaf-facing and BFT-facing signal bundle of the quad leaf arbiter.
// "master" is the traffic side (leaves + downstream), "slave" is the arbiter.
interface leaf_quad_arb_if;
    logic [48:0] din_0;
    logic [48:0] din_1;
    logic [48:0] din_2;
    logic [48:0] din_3;
    logic        resend_0;
    logic        resend_1;
    logic        resend_2;
    logic        resend_3;
    logic [48:0] dout;
    logic        dout_ready;
    logic [1:0]  grant_id;
    logic [3:0]  overflow;
    logic [3:0]  enable;

    modport master (
        output din_0, din_1, din_2, din_3, dout_ready, enable,
        input  resend_0, resend_1, resend_2, resend_3, dout, grant_id, overflow
    );

    modport slave (
        input  din_0, din_1, din_2, din_3, dout_ready, enable,
        output resend_0, resend_1, resend_2, resend_3, dout, grant_id, overflow
    );
endinterface

// File: rtl/leaf_quad_arb.sv
// Four-input leaf merger: per-input FIFOs with resend throttling and sticky
// drop flags, round-robin arbitration into one registered valid/ready output.
module leaf_quad_arb #(
    parameter int FIFO_DEPTH    = 4,
    parameter int RESEND_MARGIN = 2
) (
    input  logic           clk,
    input  logic           reset,
    leaf_quad_arb_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RESEND_CNT = CW'(FIFO_DEPTH - RESEND_MARGIN);

    logic [47:0]   mem_q    [4][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q [4];
    logic [AW-1:0] wr_ptr_d [4];
    logic [AW-1:0] rd_ptr_q [4];
    logic [AW-1:0] rd_ptr_d [4];
    logic [CW-1:0] cnt_q    [4];
    logic [CW-1:0] cnt_d    [4];
    logic [3:0]    resend_q, resend_d;
    logic [3:0]    overflow_q, overflow_d;
    logic [48:0]   dout_q, dout_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    last_q, last_d;

    logic [48:0]   din_s [4];
    logic [3:0]    cand_s;
    logic [3:0]    pop_s;
    logic [3:0]    push_s;
    logic [1:0]    gsel_s;
    logic          load_s;

    assign din_s[0] = bus.din_0;
    assign din_s[1] = bus.din_1;
    assign din_s[2] = bus.din_2;
    assign din_s[3] = bus.din_3;

    // Candidate set: non-empty FIFOs whose input is enabled for arbitration.
    always_comb begin
        cand_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            cand_s[k] = (cnt_q[k] != CW'(0)) & bus.enable[k];
        end
    end

    // Round-robin pick: the lowest rotation offset after last_grant wins.
    always_comb begin
        gsel_s = last_q;
        for (int i = 3; i >= 0; i--) begin
            gsel_s = cand_s[last_q + 2'd1 + 2'(i)] ? (last_q + 2'd1 + 2'(i)) : gsel_s;
        end
    end

    // Next-state for FIFO bookkeeping, throttle, drop flags and the output stage.
    always_comb begin
        load_s     = (~dout_q[48] | bus.dout_ready) & (|cand_s);
        pop_s      = 4'b0000;
        push_s     = 4'b0000;
        overflow_d = overflow_q;
        resend_d   = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            pop_s[k]      = load_s & (gsel_s == 2'(k));
            push_s[k]     = din_s[k][48] & ((cnt_q[k] != FULL_CNT) | pop_s[k]);
            wr_ptr_d[k]   = push_s[k] ? (wr_ptr_q[k] + AW'(1)) : wr_ptr_q[k];
            rd_ptr_d[k]   = pop_s[k]  ? (rd_ptr_q[k] + AW'(1)) : rd_ptr_q[k];
            cnt_d[k]      = cnt_q[k] + CW'(push_s[k]) - CW'(pop_s[k]);
            resend_d[k]   = (cnt_d[k] >= RESEND_CNT);
            overflow_d[k] = overflow_q[k] | (din_s[k][48] & ~push_s[k]);
        end
        dout_d  = dout_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (load_s) begin
            dout_d  = {1'b1, mem_q[gsel_s][rd_ptr_q[gsel_s]]};
            grant_d = gsel_s;
            last_d  = gsel_s;
        end else if (bus.dout_ready) begin
            dout_d[48] = 1'b0;
        end else begin
            dout_d = dout_q;
        end
    end

    // Packet storage; contents are meaningless while the occupancy count is zero.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (push_s[k]) begin
                mem_q[k][wr_ptr_q[k]] <= din_s[k][47:0];
            end
        end
    end

    // Control state; last_grant resets to 3 so input 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            resend_q   <= 4'b0000;
            overflow_q <= 4'b0000;
            dout_q     <= 49'd0;
            grant_q    <= 2'd0;
            last_q     <= 2'd3;
        end else begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            resend_q   <= resend_d;
            overflow_q <= overflow_d;
            dout_q     <= dout_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.grant_id = grant_q;
    assign bus.overflow = overflow_q;
    assign bus.resend_0 = resend_q[0];
    assign bus.resend_1 = resend_q[1];
    assign bus.resend_2 = resend_q[2];
    assign bus.resend_3 = resend_q[3];
endmodule

// File: tb/tb_leaf_quad_arb.sv
// Directed self-checking bench for leaf_quad_arb: latency, fairness,
// backpressure, throttle, overflow and mid-traffic reset.
module tb_leaf_quad_arb;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    leaf_quad_arb_if bus ();

    leaf_quad_arb #(.FIFO_DEPTH(4), .RESEND_MARGIN(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] pk(input logic [47:0] p);
        return {1'b1, p};
    endfunction

    function automatic logic [3:0] resend_v();
        return {bus.resend_3, bus.resend_2, bus.resend_1, bus.resend_0};
    endfunction

    // n-th output of the fairness burst: input n%4, its (n/4)-th packet.
    task automatic check_fair(input int n);
        check($sformatf("fair_dout_%0d", n), bus.dout, pk(48'((n % 4) * 16 + (n / 4))));
        check($sformatf("fair_gid_%0d", n), bus.grant_id, 64'(n % 4));
    endtask

    initial begin
        reset          = 1'b1;
        bus.din_0      = 49'd0;
        bus.din_1      = 49'd0;
        bus.din_2      = 49'd0;
        bus.din_3      = 49'd0;
        bus.enable     = 4'hF;
        bus.dout_ready = 1'b1;
        #2;
        check("rst_dout", bus.dout, 64'd0);
        check("rst_gid", bus.grant_id, 64'd0);
        check("rst_ovf", bus.overflow, 64'd0);
        check("rst_resend", resend_v(), 64'd0);
        tick();
        reset = 1'b0;

        // Single packet on input 2.
        bus.din_2 = pk(48'hA5);
        tick();
        bus.din_2 = 49'd0;
        check("single_not_yet", bus.dout[48], 64'd0);
        tick();
        check("single_dout", bus.dout, pk(48'hA5));
        check("single_gid", bus.grant_id, 64'd2);
        tick();
        check("single_idle", bus.dout[48], 64'd0);

        // Fresh reset so the fairness burst starts at input 0.
        reset = 1'b1;
        #1;
        check("rst2_dout", bus.dout, 64'd0);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.din_0 = pk(48'(0 * 16 + j));
            bus.din_1 = pk(48'(1 * 16 + j));
            bus.din_2 = pk(48'(2 * 16 + j));
            bus.din_3 = pk(48'(3 * 16 + j));
            tick();
            if (j > 0) check_fair(j - 1);
        end
        bus.din_0 = 49'd0;
        bus.din_1 = 49'd0;
        bus.din_2 = 49'd0;
        bus.din_3 = 49'd0;
        for (int n = 2; n < 12; n++) begin
            tick();
            check_fair(n);
        end
        tick();
        check("fair_idle", bus.dout[48], 64'd0);

        // Backpressure: output must hold for 10 cycles, then deliver the next.
        bus.dout_ready = 1'b0;
        bus.din_0 = pk(48'hB0);
        tick();
        bus.din_0 = pk(48'hB1);
        tick();
        bus.din_0 = 49'd0;
        check("bp_first", bus.dout, pk(48'hB0));
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp_hold_dout_%0d", c), bus.dout, pk(48'hB0));
            check($sformatf("bp_hold_gid_%0d", c), bus.grant_id, 64'd0);
        end
        bus.dout_ready = 1'b1;
        tick();
        check("bp_next", bus.dout, pk(48'hB1));
        check("bp_next_gid", bus.grant_id, 64'd0);
        tick();
        check("bp_idle", bus.dout[48], 64'd0);

        // Throttle: dout occupied by C0, leaf 1 pushes four times.
        bus.dout_ready = 1'b0;
        bus.din_0 = pk(48'hC0);
        tick();
        bus.din_0 = 49'd0;
        bus.din_1 = pk(48'hD0);
        tick();
        check("thr_hold", bus.dout, pk(48'hC0));
        check("thr_resend_after1", bus.resend_1, 64'd0);
        bus.din_1 = pk(48'hD1);
        tick();
        check("thr_resend_after2", bus.resend_1, 64'd1);
        bus.din_1 = pk(48'hD2);
        tick();
        bus.din_1 = pk(48'hD3);
        tick();
        bus.din_1 = 49'd0;
        check("thr_ovf", bus.overflow, 64'd0);
        check("thr_resend_full", bus.resend_1, 64'd1);
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("thr_drain_%0d", c), bus.dout, pk(48'(48'hD0 + c)));
            check($sformatf("thr_gid_%0d", c), bus.grant_id, 64'd1);
        end
        tick();
        check("thr_idle", bus.dout[48], 64'd0);
        check("thr_resend_clear", bus.resend_1, 64'd0);

        // Overflow: input 3 masked, five pushes, fifth must be dropped.
        bus.enable     = 4'b0111;
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.din_3 = pk(48'(48'hE0 + i));
            tick();
            if (i == 3) check("ovf_before", bus.overflow, 64'd0);
        end
        bus.din_3 = 49'd0;
        check("ovf_set", bus.overflow, 64'h8);
        check("ovf_resend", resend_v(), 64'h8);
        bus.enable     = 4'hF;
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("ovf_drain_%0d", c), bus.dout, pk(48'(48'hE0 + c)));
            check($sformatf("ovf_gid_%0d", c), bus.grant_id, 64'd3);
        end
        tick();
        check("ovf_idle", bus.dout[48], 64'd0);
        check("ovf_sticky", bus.overflow, 64'h8);

        // Reset mid-traffic: buffered packets vanish, input 0 wins first.
        bus.dout_ready = 1'b0;
        bus.din_0 = pk(48'hF0);
        bus.din_1 = pk(48'hF1);
        bus.din_2 = pk(48'hF2);
        bus.din_3 = pk(48'hF3);
        tick();
        bus.din_0 = 49'd0;
        bus.din_1 = 49'd0;
        bus.din_2 = 49'd0;
        bus.din_3 = 49'd0;
        tick();
        check("mid_loaded", bus.dout, pk(48'hF0));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_dout", bus.dout, 64'd0);
        check("mid_rst_gid", bus.grant_id, 64'd0);
        check("mid_rst_ovf", bus.overflow, 64'd0);
        check("mid_rst_resend", resend_v(), 64'd0);
        #2;
        reset          = 1'b0;
        bus.dout_ready = 1'b1;
        bus.din_0 = pk(48'h70);
        bus.din_1 = pk(48'h71);
        bus.din_2 = pk(48'h72);
        bus.din_3 = pk(48'h73);
        tick();
        bus.din_0 = 49'd0;
        bus.din_1 = 49'd0;
        bus.din_2 = 49'd0;
        bus.din_3 = 49'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("post_dout_%0d", c), bus.dout, pk(48'(48'h70 + c)));
            check($sformatf("post_gid_%0d", c), bus.grant_id, 64'(c));
        end
        tick();
        check("post_idle", bus.dout[48], 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
